// File: rtl/rv32_fetch_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rv32_fetch_unit_if : instruction-memory and decoder-side fetch signals     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface rv32_fetch_unit_if #(
  parameter int API_DATA_WIDTH = 32
);
  logic                      imem_req_valid_o;
  logic                      imem_req_ready_i;
  logic [API_DATA_WIDTH-1:0] imem_addr_o;
  logic                      imem_rsp_valid_i;
  logic [API_DATA_WIDTH-1:0] imem_rsp_data_i;
  logic                      redirect_i;
  logic [API_DATA_WIDTH-1:0] redirect_pc_i;
  logic                      instr_valid_o;
  logic                      instr_ready_i;
  logic [API_DATA_WIDTH-1:0] instruction_o;
  logic [API_DATA_WIDTH-1:0] pc_o;
  logic                      misalign_o;

  modport master (
    output imem_req_valid_o, imem_addr_o, instr_valid_o, instruction_o, pc_o, misalign_o,
    input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i, redirect_i, redirect_pc_i,
           instr_ready_i
  );

  modport slave (
    input  imem_req_valid_o, imem_addr_o, instr_valid_o, instruction_o, pc_o, misalign_o,
    output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i, redirect_i, redirect_pc_i,
           instr_ready_i
  );
endinterface
`default_nettype wire

// File: rtl/rv32_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rv32_fetch_unit : single-outstanding RV32 fetch with 2-entry decode FIFO   |
// | Optional macro API_FETCH_MISALIGN_EN: halt on misaligned redirect target.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rv32_fetch_unit #(
  parameter int                        API_DATA_WIDTH = 32,
  parameter logic [API_DATA_WIDTH-1:0] RESET_PC       = '0
) (
  input  logic                clk,
  input  logic                rst,
  rv32_fetch_unit_if.master   fetch
);

  localparam logic [API_DATA_WIDTH-1:0] c_nop = API_DATA_WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
`ifdef API_FETCH_MISALIGN_EN
    , S_HALT = 2'd3
`endif
  } state_t;

  state_t                    r_state, w_state_nxt;
  logic [API_DATA_WIDTH-1:0] r_fetch_pc;
  logic [API_DATA_WIDTH-1:0] r_req_pc;
  logic [1:0]                r_count;
  logic [API_DATA_WIDTH-1:0] r_fifo_pc    [2];
  logic [API_DATA_WIDTH-1:0] r_fifo_instr [2];

  logic                      w_req_valid, w_hs, w_push, w_pop, w_pend, w_mis;
  logic [API_DATA_WIDTH-1:0] w_redir_pc;

`ifdef API_FETCH_MISALIGN_EN
  logic r_mis;
  logic r_pend;  // response still owed by memory while halted
  assign w_redir_pc = fetch.redirect_pc_i;
  assign w_mis      = |fetch.redirect_pc_i[1:0];
  assign fetch.misalign_o = r_mis;
`else
  logic w_unused_lo;
  assign w_unused_lo = ^fetch.redirect_pc_i[1:0];
  assign w_redir_pc  = {fetch.redirect_pc_i[API_DATA_WIDTH-1:2], 2'b00};
  assign w_mis       = 1'b0;
  assign fetch.misalign_o = 1'b0;
`endif

  assign w_req_valid = !rst && (r_state == S_IDLE) && (r_count <= 2'd1);
  assign w_hs        = w_req_valid && fetch.imem_req_ready_i;
  assign w_push      = (r_state == S_WAIT) && fetch.imem_rsp_valid_i && !fetch.redirect_i;
  assign w_pop       = (r_count != 2'd0) && fetch.instr_ready_i && !fetch.redirect_i;

  assign fetch.imem_req_valid_o = w_req_valid;
  assign fetch.imem_addr_o      = r_fetch_pc;
  assign fetch.instr_valid_o    = (r_count != 2'd0);
  assign fetch.instruction_o    = (r_count != 2'd0) ? r_fifo_instr[0] : c_nop;
  assign fetch.pc_o             = (r_count != 2'd0) ? r_fifo_pc[0] : '0;

  // w_pend: a memory response is still owed after this cycle
  always_comb begin
    w_pend      = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_pend = w_hs;
      S_WAIT:  w_pend = !fetch.imem_rsp_valid_i;
      S_DRAIN: w_pend = !fetch.imem_rsp_valid_i;
`ifdef API_FETCH_MISALIGN_EN
      S_HALT:  w_pend = r_pend && !fetch.imem_rsp_valid_i;
`endif
      default: w_pend = 1'b0;
    endcase

    if (fetch.redirect_i) begin
`ifdef API_FETCH_MISALIGN_EN
      if (w_mis)
        w_state_nxt = S_HALT;
      else
`endif
        w_state_nxt = w_pend ? S_DRAIN : S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = w_hs ? S_WAIT : S_IDLE;
        S_WAIT:  w_state_nxt = fetch.imem_rsp_valid_i ? S_IDLE : S_WAIT;
        S_DRAIN: w_state_nxt = fetch.imem_rsp_valid_i ? S_IDLE : S_DRAIN;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_fetch_pc      <= RESET_PC;
      r_req_pc        <= '0;
      r_count         <= 2'd0;
      r_fifo_pc[0]    <= '0;
      r_fifo_pc[1]    <= '0;
      r_fifo_instr[0] <= c_nop;
      r_fifo_instr[1] <= c_nop;
`ifdef API_FETCH_MISALIGN_EN
      r_mis           <= 1'b0;
      r_pend          <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (fetch.redirect_i)
        r_fetch_pc <= w_redir_pc;
      else if (w_hs)
        r_fetch_pc <= r_fetch_pc + API_DATA_WIDTH'(4);
      if (w_hs)
        r_req_pc <= r_fetch_pc;
`ifdef API_FETCH_MISALIGN_EN
      r_pend <= w_pend;
      if (fetch.redirect_i)
        r_mis <= w_mis;
`endif
      if (fetch.redirect_i) begin
        r_count <= 2'd0;
      end else begin
        case ({w_push, w_pop})
          2'b10: begin
            r_fifo_pc[r_count[0]]    <= r_req_pc;
            r_fifo_instr[r_count[0]] <= fetch.imem_rsp_data_i;
            r_count                  <= r_count + 2'd1;
          end
          2'b01: begin
            r_fifo_pc[0]    <= r_fifo_pc[1];
            r_fifo_instr[0] <= r_fifo_instr[1];
            r_count         <= r_count - 2'd1;
          end
          2'b11: begin
            // head leaves; new entry lands behind whatever remains
            if (r_count == 2'd1) begin
              r_fifo_pc[0]    <= r_req_pc;
              r_fifo_instr[0] <= fetch.imem_rsp_data_i;
            end else begin
              r_fifo_pc[0]    <= r_fifo_pc[1];
              r_fifo_instr[0] <= r_fifo_instr[1];
              r_fifo_pc[1]    <= r_req_pc;
              r_fifo_instr[1] <= fetch.imem_rsp_data_i;
            end
          end
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rv32_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rv32_fetch_unit : randomized bench with queue-based fetch reference     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_rv32_fetch_unit;

  localparam logic [31:0] c_nop = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv32_fetch_unit_if #(.API_DATA_WIDTH(32)) bus();

  rv32_fetch_unit #(.API_DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst   (rst),
    .fetch (bus)
  );

  int checks   = 0;
  int failures = 0;

  // reference: program counter, in-order decode queue, one memory slot
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_out_addr = 32'h0;
  bit          m_out = 1'b0;
  bit          m_stale = 1'b0;
  bit          m_halt = 1'b0;
  bit          m_mis = 1'b0;
  bit          m_prev_rst = 1'b0;
  logic [63:0] q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit redir, input logic [31:0] rpc,
                     input bit rdy, input bit rsp, input bit drdy);
    bit          exp_rv, hs, pop, mis;
    logic [31:0] tgt, data;
    logic [63:0] head;
    @(negedge clk);
    rst                  = r;
    bus.redirect_i       = redir;
    bus.redirect_pc_i    = rpc;
    bus.imem_req_ready_i = rdy;
    bus.imem_rsp_valid_i = rsp;
    data                 = m_out ? mem_word(m_out_addr) : $urandom;
    bus.imem_rsp_data_i  = data;
    bus.instr_ready_i    = drdy;
    #1;
    if (r) begin
      chk("rst_req_valid", {31'b0, bus.imem_req_valid_o}, 32'h0);
      if (m_prev_rst) begin
        chk("rst_instr_valid", {31'b0, bus.instr_valid_o}, 32'h0);
        chk("rst_instruction", bus.instruction_o, c_nop);
        chk("rst_pc", bus.pc_o, 32'h0);
        chk("rst_misalign", {31'b0, bus.misalign_o}, 32'h0);
      end
      m_pc = 32'h0; m_out = 1'b0; m_stale = 1'b0; m_halt = 1'b0; m_mis = 1'b0;
      q.delete();
      m_prev_rst = 1'b1;
      return;
    end
    m_prev_rst = 1'b0;

    exp_rv = !m_out && !m_halt && (q.size() <= 1);
    chk("req_valid", {31'b0, bus.imem_req_valid_o}, {31'b0, exp_rv});
    if (exp_rv) chk("req_addr", bus.imem_addr_o, m_pc);
    chk("instr_valid", {31'b0, bus.instr_valid_o}, {31'b0, q.size() != 0});
    if (q.size() != 0) begin
      head = q[0];
      chk("instruction", bus.instruction_o, head[31:0]);
      chk("pc_o", bus.pc_o, head[63:32]);
    end else begin
      chk("empty_nop", bus.instruction_o, c_nop);
      chk("empty_pc", bus.pc_o, 32'h0);
    end
    chk("misalign", {31'b0, bus.misalign_o}, {31'b0, m_mis});

    hs  = exp_rv && rdy;
    pop = (q.size() != 0) && drdy;
    if (redir) begin
`ifdef API_FETCH_MISALIGN_EN
      mis = (rpc[1:0] != 2'b00);
      tgt = rpc;
`else
      mis = 1'b0;
      tgt = {rpc[31:2], 2'b00};
`endif
      q.delete();
      m_pc   = tgt;
      m_mis  = mis;
      m_halt = mis;
      if (hs) begin
        m_out = 1'b1; m_stale = 1'b1;
      end else if (m_out && rsp) begin
        m_out = 1'b0;
      end else if (m_out) begin
        m_stale = 1'b1;
      end
    end else begin
      if (pop) void'(q.pop_front());
      if (m_out && rsp) begin
        if (!m_stale) q.push_back({m_out_addr, data});
        m_out = 1'b0;
      end
      if (hs) begin
        m_out = 1'b1; m_stale = 1'b0; m_out_addr = m_pc; m_pc = m_pc + 32'd4;
      end
    end
  endtask

  initial begin
    bus.redirect_i = 1'b0; bus.redirect_pc_i = '0; bus.imem_req_ready_i = 1'b0;
    bus.imem_rsp_valid_i = 1'b0; bus.imem_rsp_data_i = '0; bus.instr_ready_i = 1'b0;

    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, 0, 1);

    // steady stream: memory answers the cycle after each handshake
    for (int i = 0; i < 16; i++) cyc(0, 0, 0, 1, m_out, 1);

    // decoder stalls; FIFO fills to two and requests stop
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, m_out, 0);
    for (int i = 0; i < 6; i++)  cyc(0, 0, 0, 1, m_out, 1);

    // redirect while waiting; the late response must be dropped
    for (int i = 0; i < 4 && !m_out; i++) cyc(0, 0, 0, 1, 0, 1);
    cyc(0, 1, 32'h0000_0100, 1, 0, 1);
    cyc(0, 0, 0, 1, 1, 1);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, m_out, 1);

    // redirect coincident with the response
    for (int i = 0; i < 4 && !m_out; i++) cyc(0, 0, 0, 1, 0, 1);
    cyc(0, 1, 32'h0000_0300, 1, 1, 1);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, m_out, 1);

    // address wrap at the top of the space
    for (int i = 0; i < 4 && m_out; i++) cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 1, 32'hFFFF_FFFC, 0, 0, 1);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, m_out, 1);

    // misaligned then aligned redirect
    for (int i = 0; i < 4 && m_out; i++) cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 1, 32'h0000_0102, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, m_out, 1);
    cyc(0, 1, 32'h0000_0200, 0, 0, 1);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, m_out, 1);

    // reset with a request outstanding; the stray response is ignored
    for (int i = 0; i < 4 && !m_out; i++) cyc(0, 0, 0, 1, 0, 1);
    cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, m_out, 1);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      logic [31:0] rpc;
      rpc = $urandom;
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      cyc($urandom_range(0, 249) == 0, $urandom_range(0, 11) == 0, rpc,
          $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
